data_mem_access: RTL and testbench
==================================

Name: data_mem_access

Overview:
- Executes the load/store requests issued by the processor's control decoder: consumes the decoded data-memory read/write enables, access size and extension flag.
- Aligns lanes and generates byte enables; runs a req/ack handshake with a variable-latency data memory.
- Extends load data to 32 bits.
- Drives a stall that the datapath ANDs into the PC enable until the access completes.

Parameters:
- ADDR_W, 32, byte-address width; the bus carries address bits [ADDR_W-1:2].
- TIMEOUT, 16, maximum cycles in REQ waiting for ack before abort (≥1).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- re_in  input  1  load request (decoder data_mem_re).
- we_in  input  1  store request (decoder data_mem_we).
- size_in  input  2  00 byte, 01 halfword, 11 word; 10 is illegal.
- zext_in  input  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- addr_in  input  ADDR_W  byte address from ALU.
- wdata_in  input  32  store data (rt), right-justified.
- stall_out  output  1  1 = hold PC/pipeline.
- rdata_out  output  32  extended load result, valid when done_out=1.
- done_out  output  1  one-cycle pulse, access complete.
- err_out  output  1  one-cycle pulse, access failed.
- err_code_out  output  2  01 misaligned/illegal size, 10 timeout, 11 re&we conflict; 00 otherwise.
- mem_req_out  output  1  bus request.
- mem_we_out  output  1  bus write.
- mem_addr_out  output  ADDR_W-2  word address.
- mem_be_out  output  4  byte enables, bit n = byte lane n (little-endian).
- mem_wdata_out  output  32  lane-replicated store data.
- mem_rdata_in  input  32  read word.
- mem_ack_in  input  1  completes the request in the cycle it is seen with mem_req_out=1.

Behaviour:
- Reset (async, immediate): state IDLE, timeout counter 0.
  - All outputs 0: stall, done, err, err_code, req, we, be, addr, wdata, rdata.
  - A reset during REQ drops mem_req_out in the same cycle; no done/err follows.
- FSM states: IDLE, REQ, DONE.
- Legal access: (re_in^we_in)=1, size≠10, and alignment holds:
  - halfword: addr[0]=0
  - word: addr[1:0]=00
- IDLE:
  - Legal access: stall_out=1 combinationally. Capture addr, be, wdata, size, zext, we. Next state REQ.
  - Illegal access: err_out=1 and err_code set in the same cycle. Priority 11 over 01. stall_out=0; no bus activity; stay IDLE.
  - Neither re_in nor we_in: idle.
- REQ:
  - mem_req_out=1; stall_out=1. Bus outputs are held from registers and are stable until ack.
  - Counter increments each cycle without ack.
  - mem_ack_in=1: for loads, register the extended mem_rdata_in into rdata_out. Next state DONE.
  - Counter reaches TIMEOUT-1 with no ack: abort, set rdata_out=0 and err_code=10, next state DONE.
- DONE (exactly one cycle): stall_out=0; done_out=1, or err_out=1 for a timeout. Pipeline advances at this edge. Next state IDLE, counter cleared. Inputs are ignored in DONE.
- Minimum latency with same-cycle ack: request at cycle 0 (IDLE), REQ at cycle 1, DONE at cycle 2. Two stall cycles.
- Byte enables:
  - byte: 1<<addr[1:0]
  - halfword: addr[1]=0 → 0011, addr[1]=1 → 1100
  - word: 1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata
  - mem_wdata_out=0 for loads.
- Load extraction:
  - byte: lane addr[1:0]
  - halfword: lanes selected by addr[1]
  - Result is zero-extended if zext=1, else sign-extended; word loads are passed through.
- rdata_out holds its last value until the next completed load or timeout.
- Stores leave rdata_out unchanged.

Test Plan:
- Reset: assert rst_n_in=0 mid-REQ → mem_req_out falls immediately; all outputs 0; no done_out after release.
- lb sign-extend: re=1, size=00, zext=0, addr=0x103, rdata_in=0x80FF_1234, ack on first REQ cycle → stall 2 cycles, done at cycle 2, rdata_out=0xFFFF_FF80.
- lhu zero-extend: addr=0x102, size=01, zext=1, rdata_in=0xBEEF_0000, ack delayed 3 cycles → be=1100, rdata_out=0x0000_BEEF, stall 5 cycles.
- sb: we=1, size=00, addr=0x201, wdata=0x0000_00A5 → mem_we=1, be=0010, mem_wdata=0xA5A5_A5A5, addr_out=0x80.
- Misaligned sw: addr=0x202, size=11 → err_out=1 and err_code=01 in the same cycle, no mem_req_out, stall 0. Then re=1 and we=1 → err_code=11.
- Timeout: TIMEOUT=16, legal lw, never ack → mem_req_out high 16 cycles, then err_out=1, err_code=10, rdata_out=0, back to IDLE.

Source files
------------

// File: rtl/data_mem_access.sv
// -----------------------------------------------------------------------------
// data_mem_access
//
// Executes one load or store on a variable-latency, word-wide data memory on
// behalf of the processor datapath. The decoder supplies read/write enables,
// access size and the zero/sign-extension flag; the ALU supplies the byte
// address. The block checks legality, builds byte enables and lane-replicated
// store data, runs a req/ack handshake with a timeout, extends the load data
// to 32 bits and holds the pipeline (stall_out) until the access completes.
//
// Ports:
//   clk_in, rst_n_in     clock (rising edge), asynchronous active-low reset
//   re_in, we_in         load / store request (exactly one must be set)
//   size_in              00 byte, 01 halfword, 11 word, 10 illegal
//   zext_in              loads: 1 zero-extend, 0 sign-extend
//   addr_in              byte address
//   wdata_in             store data, right-justified
//   stall_out            1 = hold PC / pipeline
//   rdata_out            extended load result (valid with done_out)
//   done_out, err_out    one-cycle completion / failure pulses
//   err_code_out         01 misaligned/illegal size, 10 timeout, 11 re&we
//   mem_*                word-addressed memory bus (req/ack handshake)
//   state_dbg_out        current FSM state (00 IDLE, 01 REQ, 10 DONE)
//
// Handshake: mem_req_out is high for every REQ cycle and all other mem_*
// outputs are held from registers while it is high. The memory completes the
// request in any cycle where it drives mem_ack_in=1 while mem_req_out=1; the
// read word on mem_rdata_in is sampled in that same cycle. Outside REQ all
// mem_* outputs are driven to 0.
// -----------------------------------------------------------------------------
module data_mem_access #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              re_in,
  input  logic              we_in,
  input  logic [1:0]        size_in,
  input  logic              zext_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  output logic              stall_out,
  output logic [31:0]       rdata_out,
  output logic              done_out,
  output logic              err_out,
  output logic [1:0]        err_code_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-3:0] mem_addr_out,
  output logic [3:0]        mem_be_out,
  output logic [31:0]       mem_wdata_out,
  input  logic [31:0]       mem_rdata_in,
  input  logic              mem_ack_in,
  output logic [1:0]        state_dbg_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_ILL  = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] EC_NONE     = 2'b00;
  localparam logic [1:0] EC_ALIGN    = 2'b01;
  localparam logic [1:0] EC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EC_CONFLICT = 2'b11;

  // Registered state
  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [ADDR_W-3:0]  addr_q,    addr_d;
  logic [1:0]         lane_q,    lane_d;
  logic [3:0]         be_q,      be_d;
  logic [31:0]        wdata_q,   wdata_d;
  logic [1:0]         size_q,    size_d;
  logic               zext_q,    zext_d;
  logic               we_q,      we_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        rdata_q,   rdata_d;

  // Request decode (combinational, only meaningful in IDLE)
  logic        access;
  logic        conflict;
  logic        misalign;
  logic        legal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_ext;

  // Gating with rst_n_in keeps every output at 0 while reset is held,
  // even if the decoder happens to present a request.
  assign access   = rst_n_in & (re_in | we_in);
  assign conflict = re_in & we_in;

  always_comb begin
    misalign = 1'b0;
    case (size_in)
      SZ_HALF: misalign = addr_in[0];
      SZ_WORD: misalign = (addr_in[1:0] != 2'b00);
      SZ_ILL:  misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  assign legal = access & ~conflict & ~misalign;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata_in;
    case (size_in)
      SZ_BYTE: begin
        be_calc    = 4'b0001 << addr_in[1:0];
        wdata_calc = {4{wdata_in[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata_in[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_in;
      end
    endcase
  end

  // Lane extraction and extension of the returned word, using the captured
  // size/lane so the result does not depend on inputs changing during REQ.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte  = mem_rdata_in[{lane_q, 3'b000} +: 8];
    ld_half  = lane_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    load_ext = mem_rdata_in;
    case (size_q)
      SZ_BYTE: load_ext = zext_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_ext = zext_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata_in;
    endcase
  end

  // Next-state and pulse outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    zext_d       = zext_q;
    we_d         = we_q;
    timeout_d    = timeout_q;
    rdata_d      = rdata_q;
    stall_out    = 1'b0;
    done_out     = 1'b0;
    err_out      = 1'b0;
    err_code_out = EC_NONE;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (legal) begin
          stall_out = 1'b1;
          addr_d    = addr_in[ADDR_W-1:2];
          lane_d    = addr_in[1:0];
          be_d      = be_calc;
          wdata_d   = we_in ? wdata_calc : 32'h0;
          size_d    = size_in;
          zext_d    = zext_in;
          we_d      = we_in;
          state_d   = S_REQ;
        end else if (access) begin
          // Rejected in the same cycle; conflict wins over alignment.
          err_out      = 1'b1;
          err_code_out = conflict ? EC_CONFLICT : EC_ALIGN;
        end
      end

      S_REQ: begin
        stall_out = 1'b1;
        if (mem_ack_in) begin
          if (!we_q) rdata_d = load_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = 32'h0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (timeout_q) begin
          err_out      = 1'b1;
          err_code_out = EC_TIMEOUT;
        end else begin
          done_out = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lane_q    <= 2'b00;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      size_q    <= 2'b00;
      zext_q    <= 1'b0;
      we_q      <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      zext_q    <= zext_d;
      we_q      <= we_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  // Bus outputs come straight from registers and are quiet outside REQ.
  assign mem_req_out   = (state_q == S_REQ);
  assign mem_we_out    = mem_req_out & we_q;
  assign mem_addr_out  = mem_req_out ? addr_q  : '0;
  assign mem_be_out    = mem_req_out ? be_q    : 4'b0000;
  assign mem_wdata_out = mem_req_out ? wdata_q : 32'h0;
  assign rdata_out     = rdata_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              re_in;
  logic              we_in;
  logic [1:0]        size_in;
  logic              zext_in;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       wdata_in;
  logic              stall_out;
  logic [31:0]       rdata_out;
  logic              done_out;
  logic              err_out;
  logic [1:0]        err_code_out;
  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-3:0] mem_addr_out;
  logic [3:0]        mem_be_out;
  logic [31:0]       mem_wdata_out;
  logic [31:0]       mem_rdata_in;
  logic              mem_ack_in;
  logic [1:0]        state_dbg_out;

  data_mem_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .re_in         (re_in),
    .we_in         (we_in),
    .size_in       (size_in),
    .zext_in       (zext_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .stall_out     (stall_out),
    .rdata_out     (rdata_out),
    .done_out      (done_out),
    .err_out       (err_out),
    .err_code_out  (err_code_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_be_out    (mem_be_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata_in),
    .mem_ack_in    (mem_ack_in),
    .state_dbg_out (state_dbg_out)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  // Entry: {done, err, err_code, rdata} expected in the DONE cycle.
  logic [35:0] exp_q[$];
  logic [35:0] mon_exp;
  logic [35:0] mon_got;
  logic [31:0] model_rdata;
  int          checks;
  int          errors;
  int          completions;

  always @(negedge clk) begin
    if (rst_n && (state_dbg_out == 2'b10 || done_out)) begin
      completions++;
      checks++;
      mon_got = {done_out, err_out, err_code_out, rdata_out};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL completion: unexpected {done,err,code,rdata}=%h, none expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL completion: {done,err,code,rdata} got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------------------------------------------------------- model
  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    case (size)
      2'b00: case (a[1:0])
               2'd0: return 4'b0001;
               2'd1: return 4'b0010;
               2'd2: return 4'b0100;
               default: return 4'b1000;
             endcase
      2'b01: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic we, input logic [1:0] size, input logic [31:0] d);
    if (!we) return 32'h0;
    case (size)
      2'b00: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_ld(input logic [1:0] size, input logic zext,
                                           input logic [31:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00: return zext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01: return zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic idle_inputs();
    re_in    = 1'b0;
    we_in    = 1'b0;
    size_in  = 2'b00;
    zext_in  = 1'b0;
    addr_in  = '0;
    wdata_in = 32'h0;
  endtask

  // Starts just after a rising edge in IDLE, returns just after the rising
  // edge that brings the DUT back to IDLE.
  task automatic run_access(input logic re, input logic we, input logic [1:0] size,
                            input logic zext, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int ack_delay, input string name);
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          stalls;
    bit          acked;
    e_be   = model_be(size, addr);
    e_wd   = model_wd(we, size, wdata);
    if (re) model_rdata = model_ld(size, zext, addr, rword);
    exp_q.push_back({1'b1, 1'b0, 2'b00, model_rdata});
    stalls = 0;
    acked  = 1'b0;
    re_in = re; we_in = we; size_in = size; zext_in = zext; addr_in = addr; wdata_in = wdata;
    @(negedge clk);
    checks++;
    if ({stall_out, mem_req_out, err_out} !== 3'b100) begin
      errors++;
      $display("FAIL %s issue: {stall,req,err} got %b expected 100", name, {stall_out, mem_req_out, err_out});
    end
    stalls++;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 0; k < 64; k++) begin
      mem_ack_in   = (k == ack_delay);
      mem_rdata_in = (k == ack_delay) ? rword : $urandom;
      @(negedge clk);
      checks++;
      if ({mem_req_out, stall_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out} !==
          {1'b1, 1'b1, we, addr[31:2], e_be, e_wd}) begin
        errors++;
        $display("FAIL %s bus: req=%b stall=%b we=%b addr=%h be=%b wd=%h expected we=%b addr=%h be=%b wd=%h",
                 name, mem_req_out, stall_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
                 we, addr[31:2], e_be, e_wd);
      end
      stalls++;
      @(posedge clk); #1;
      if (k == ack_delay) begin
        mem_ack_in = 1'b0;
        acked      = 1'b1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!acked || {stall_out, mem_req_out} !== 2'b00 || stalls != ack_delay + 2) begin
      errors++;
      $display("FAIL %s done_cycle: stall=%b req=%b stall_cycles=%0d expected 0 0 %0d",
               name, stall_out, mem_req_out, stalls, ack_delay + 2);
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mem_ack_in = 1'b0;
    mem_rdata_in = 32'h0;
    model_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall_out, rdata_out, done_out, err_out, err_code_out, mem_req_out, mem_we_out,
         mem_addr_out, mem_be_out, mem_wdata_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b rdata=%h done=%b err=%b code=%b req=%b we=%b addr=%h be=%b wd=%h expected all 0",
               stall_out, rdata_out, done_out, err_out, err_code_out, mem_req_out, mem_we_out,
               mem_addr_out, mem_be_out, mem_wdata_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lb_sign();
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0, "lb");
    @(negedge clk);
    checks++;
    if (rdata_out !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_rdata: got %h expected ffffff80", rdata_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lhu_zero();
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hBEEF_0000, 3, "lhu");
    @(negedge clk);
    checks++;
    if (rdata_out !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL lhu_rdata: got %h expected 0000beef", rdata_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sb();
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00A5, 32'h1234_5678, 1, "sb");
    @(negedge clk);
    checks++;
    if (rdata_out !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL sb_rdata_held: got %h expected 0000beef", rdata_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic        t_re [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        t_we [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  t_sz [5] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b01};
    logic [31:0] t_ad [5] = '{32'h202, 32'h200, 32'h100, 32'h101, 32'h103};
    logic [1:0]  t_ec [5] = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 5; i++) begin
      re_in = t_re[i]; we_in = t_we[i]; size_in = t_sz[i]; addr_in = t_ad[i]; wdata_in = $urandom;
      #1;
      checks++;
      if ({err_out, err_code_out, stall_out, mem_req_out} !== {1'b1, t_ec[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL illegal_%0d: err=%b code=%b stall=%b req=%b expected 1 %b 0 0",
                 i, err_out, err_code_out, stall_out, mem_req_out, t_ec[i]);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({err_out, mem_req_out, stall_out} !== 3'b000) begin
        errors++;
        $display("FAIL illegal_stay_idle_%0d: err=%b req=%b stall=%b expected 000", i, err_out, mem_req_out, stall_out);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles  = 0;
    model_rdata = 32'h0;
    exp_q.push_back({1'b0, 1'b1, 2'b10, 32'h0});
    re_in = 1'b1; size_in = 2'b11; addr_in = 32'h300;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!mem_req_out) break;
      req_cycles++;
    end
    checks++;
    if (req_cycles != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_req_cycles: got %0d expected %0d", req_cycles, TIMEOUT);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({state_dbg_out, rdata_out, err_out} !== {2'b00, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_after: state=%b rdata=%h err=%b expected 00 00000000 0", state_dbg_out, rdata_out, err_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0]  sizes [3] = '{2'b00, 2'b01, 2'b11};
    logic [1:0]  sz;
    logic [31:0] a;
    logic        st;
    for (int i = 0; i < 20; i++) begin
      sz = sizes[$urandom_range(0, 2)];
      a  = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b11) a[1:0] = 2'b00;
      st = ($urandom_range(0, 2) == 0);
      run_access(!st, st, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                 $urandom_range(0, 4), "random");
    end
  endtask

  task automatic test_reset_mid_req();
    int done_cnt;
    re_in = 1'b1; size_in = 2'b11; addr_in = 32'h400;
    @(posedge clk); #1;
    idle_inputs();
    #2;
    rst_n = 1'b0;
    model_rdata = 32'h0;
    #1;
    checks++;
    if ({stall_out, rdata_out, done_out, err_out, err_code_out, mem_req_out, mem_we_out,
         mem_addr_out, mem_be_out, mem_wdata_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_req: req=%b stall=%b rdata=%h be=%b addr=%h expected all 0",
               mem_req_out, stall_out, rdata_out, mem_be_out, mem_addr_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    mem_ack_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done_out || err_out || mem_req_out) done_cnt++;
    end
    mem_ack_in = 1'b0;
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL reset_no_done: activity cycles got %0d expected 0", done_cnt);
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    checks      = 0;
    errors      = 0;
    completions = 0;
    test_reset();
    test_lb_sign();
    test_lhu_zero();
    test_sb();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid_req();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d completions never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
